// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two cache-controller ports and the external memory port
// shared through mem_bus_arbiter.
interface mem_bus_arbiter_if;
    logic        m0_cs_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_data_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o;

    logic        m1_cs_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_data_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o;

    logic        mem_cs_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    logic [1:0]  gnt_o;
    logic        bus_err_o;

    // slave is the arbiter's view; master is the masters-plus-memory side.
    modport slave (
        input  m0_cs_i, m0_we_i, m0_addr_i, m0_data_i,
        input  m1_cs_i, m1_we_i, m1_addr_i, m1_data_i,
        input  mem_data_i, mem_ack_i,
        output m0_data_o, m0_ack_o, m1_data_o, m1_ack_o,
        output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        output gnt_o, bus_err_o
    );

    modport master (
        output m0_cs_i, m0_we_i, m0_addr_i, m0_data_i,
        output m1_cs_i, m1_we_i, m1_addr_i, m1_data_i,
        output mem_data_i, mem_ack_i,
        input  m0_data_o, m0_ack_o, m1_data_o, m1_ack_o,
        input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        input  gnt_o, bus_err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master burst arbiter for the external memory bus (m0 = I-cache, m1 = D-cache)
// with a mandatory one-cycle turnaround between owners and a sticky ack-timeout flag.
module mem_bus_arbiter #(
    parameter bit          RR_EN   = 1'b0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    // Counting stops one short so the flag lands in the same edge that to_cnt reaches TIMEOUT.
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    logic        last_gnt;
    logic [15:0] to_cnt;
    logic        bus_err;
    logic        owner_cs;
    logic        enter0;
    logic        enter1;

    assign enter0 = (state == IDLE) && (state_next == OWN0);
    assign enter1 = (state == IDLE) && (state_next == OWN1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
            to_cnt   <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (enter0 || enter1) begin
                last_gnt <= enter1;
                to_cnt   <= '0;
            end else if (owner_cs) begin
                if (bus.mem_ack_i) begin
                    to_cnt <= '0;
                end else if (to_cnt != 16'hFFFF) begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
            if (owner_cs && !bus.mem_ack_i && (to_cnt >= TIMEOUT_CNT - 16'd1)) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.m0_cs_i && bus.m1_cs_i) begin
                    state_next = (RR_EN && last_gnt) ? OWN0 : OWN1;
                end else if (bus.m1_cs_i) begin
                    state_next = OWN1;
                end else if (bus.m0_cs_i) begin
                    state_next = OWN0;
                end
            end
            OWN0:    if (!bus.m0_cs_i) state_next = IDLE;
            OWN1:    if (!bus.m1_cs_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Everything defaults to zero so IDLE and the non-owner see a quiet bus.
    always_comb begin
        bus.mem_cs_o   = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.mem_addr_o = '0;
        bus.mem_data_o = '0;
        bus.m0_ack_o   = 1'b0;
        bus.m0_data_o  = '0;
        bus.m1_ack_o   = 1'b0;
        bus.m1_data_o  = '0;
        bus.gnt_o      = 2'b00;
        bus.bus_err_o  = bus_err;
        owner_cs       = 1'b0;
        case (state)
            OWN0: begin
                bus.gnt_o      = 2'b01;
                bus.mem_cs_o   = bus.m0_cs_i;
                bus.mem_we_o   = bus.m0_we_i;
                bus.mem_addr_o = bus.m0_addr_i;
                bus.mem_data_o = bus.m0_data_i;
                bus.m0_ack_o   = bus.mem_ack_i;
                bus.m0_data_o  = bus.mem_data_i;
                owner_cs       = bus.m0_cs_i;
            end
            OWN1: begin
                bus.gnt_o      = 2'b10;
                bus.mem_cs_o   = bus.m1_cs_i;
                bus.mem_we_o   = bus.m1_we_i;
                bus.mem_addr_o = bus.m1_addr_i;
                bus.mem_data_o = bus.m1_data_i;
                bus.m1_ack_o   = bus.mem_ack_i;
                bus.m1_data_o  = bus.mem_data_i;
                owner_cs       = bus.m1_cs_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed-priority and a round-robin instance share one
// stimulus stream and are both checked every cycle against an ownership model.
module tb_mem_bus_arbiter;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    mem_bus_arbiter_if ifp ();
    mem_bus_arbiter_if irr ();

    mem_bus_arbiter #(.RR_EN(1'b0), .TIMEOUT(TMO)) dut_fp (.clk(clk), .rst(rst), .bus(ifp.slave));
    mem_bus_arbiter #(.RR_EN(1'b1), .TIMEOUT(TMO)) dut_rr (.clk(clk), .rst(rst), .bus(irr.slave));

    int checks = 0;
    int errors = 0;

    // Model per instance (0 = fixed, 1 = round-robin): owner 0 none / 1 m0 / 2 m1.
    int own  [2];
    int last [2];
    int cnt  [2];
    bit err  [2];

    int          words_left [2];
    logic [31:0] addr [2];
    logic        cs   [2];
    logic        we   [2];
    logic [31:0] wdata[2];
    logic        ack;
    logic [31:0] rdata;
    bit          refill;
    bit          rand_cs;
    bit          ack_phase;
    int          ack_mode;
    int          drv_sel;
    bit          rec;
    logic [1:0]  gq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; last[k] = 0; cnt[k] = 0; err[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int w;
        if (!rst) begin
            own[k] = 0; last[k] = 0; cnt[k] = 0; err[k] = 1'b0;
            return;
        end
        if (own[k] == 0) begin
            if (cs[0] || cs[1]) begin
                if (cs[0] && cs[1]) w = (k == 1) ? 1 - last[k] : 1;
                else                w = cs[1] ? 1 : 0;
                own[k] = w + 1; last[k] = w; cnt[k] = 0;
            end
        end else if (!cs[own[k]-1]) begin
            own[k] = 0;
        end else if (ack) begin
            cnt[k] = 0;
        end else begin
            if (cnt[k] < 65535) cnt[k]++;
            if (cnt[k] >= TMO) err[k] = 1'b1;
        end
    endtask

    task automatic check_dut(input int k, input logic [1:0] gnt, input logic mcs, input logic mwe,
                             input logic [31:0] maddr, input logic [31:0] mdata,
                             input logic a0, input logic [31:0] d0,
                             input logic a1, input logic [31:0] d1, input logic be);
        string p;
        int o;
        logic e_cs, e_we, e_a0, e_a1;
        logic [31:0] e_addr, e_data, e_d0, e_d1, e_gnt;
        p = (k == 0) ? "fp" : "rr";
        o = own[k] - 1;
        e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0; e_gnt = '0;
        if (o >= 0) begin
            e_cs = cs[o]; e_we = we[o]; e_addr = addr[o]; e_data = wdata[o];
            e_gnt = 32'(1 << o);
        end
        e_a0 = (o == 0) ? ack : 1'b0;
        e_a1 = (o == 1) ? ack : 1'b0;
        e_d0 = (o == 0) ? rdata : 32'h0;
        e_d1 = (o == 1) ? rdata : 32'h0;
        check({p, "_gnt"},      32'(gnt), e_gnt);
        check({p, "_mem_cs"},   32'(mcs), 32'(e_cs));
        check({p, "_mem_we"},   32'(mwe), 32'(e_we));
        check({p, "_mem_addr"}, maddr,    e_addr);
        check({p, "_mem_data"}, mdata,    e_data);
        check({p, "_m0_ack"},   32'(a0),  32'(e_a0));
        check({p, "_m0_data"},  d0,       e_d0);
        check({p, "_m1_ack"},   32'(a1),  32'(e_a1));
        check({p, "_m1_data"},  d1,       e_d1);
        check({p, "_bus_err"},  32'(be),  32'(err[k]));
    endtask

    task automatic drive(input int o);
        for (int m = 0; m < 2; m++) begin
            cs[m]    = (words_left[m] != 0);
            we[m]    = 1'($urandom_range(0, 1));
            wdata[m] = $urandom;
        end
        case (ack_mode)
            0:       ack = (o >= 0 && cs[o]) ? ack_phase : 1'b0;
            1:       ack = 1'b0;
            2:       ack = 1'b1;
            default: ack = 1'($urandom_range(0, 1));
        endcase
        rdata = $urandom;
        ifp.m0_cs_i = cs[0]; ifp.m0_we_i = we[0]; ifp.m0_addr_i = addr[0]; ifp.m0_data_i = wdata[0];
        ifp.m1_cs_i = cs[1]; ifp.m1_we_i = we[1]; ifp.m1_addr_i = addr[1]; ifp.m1_data_i = wdata[1];
        ifp.mem_ack_i = ack; ifp.mem_data_i = rdata;
        irr.m0_cs_i = cs[0]; irr.m0_we_i = we[0]; irr.m0_addr_i = addr[0]; irr.m0_data_i = wdata[0];
        irr.m1_cs_i = cs[1]; irr.m1_we_i = we[1]; irr.m1_addr_i = addr[1]; irr.m1_data_i = wdata[1];
        irr.mem_ack_i = ack; irr.mem_data_i = rdata;
    endtask

    // One bus cycle: drive after the falling edge, check, then advance the model at the rising edge.
    task automatic applyStimulus();
        int o;
        o = own[drv_sel] - 1;
        drive(o);
        #1;
        check_dut(0, ifp.gnt_o, ifp.mem_cs_o, ifp.mem_we_o, ifp.mem_addr_o, ifp.mem_data_o,
                  ifp.m0_ack_o, ifp.m0_data_o, ifp.m1_ack_o, ifp.m1_data_o, ifp.bus_err_o);
        check_dut(1, irr.gnt_o, irr.mem_cs_o, irr.mem_we_o, irr.mem_addr_o, irr.mem_data_o,
                  irr.m0_ack_o, irr.m0_data_o, irr.m1_ack_o, irr.m1_data_o, irr.bus_err_o);
        if (rec && ((gq.size() == 0) ? (irr.gnt_o != 2'b00) : (irr.gnt_o != gq[$])))
            gq.push_back(irr.gnt_o);
        @(posedge clk);
        model_step(0);
        model_step(1);
        for (int m = 0; m < 2; m++) begin
            if (words_left[m] == 0) begin
                if (refill) words_left[m] = 2;
                else if (rand_cs && $urandom_range(0, 3) == 0) words_left[m] = $urandom_range(1, 4);
            end else if (o == m && ack) begin
                words_left[m]--;
                addr[m] = addr[m] + 32'd4;
            end
        end
        ack_phase = ~ack_phase;
        @(negedge clk);
    endtask

    task automatic runUntilIdle(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (words_left[0] != 0 || words_left[1] != 0 || own[0] != 0 || own[1] != 0) begin
            if (n == max_cycles) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s_bound observed=%0d cycles expected=idle", tag, n);
                return;
            end
            applyStimulus();
            n++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs_fp, input logic [31:0] obs_rr,
                               input logic [31:0] exp);
        check({tag, "_fp"}, obs_fp, exp);
        check({tag, "_rr"}, obs_rr, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        model_reset();
        refill = 1'b0; rand_cs = 1'b0; ack_phase = 1'b0; ack_mode = 0; drv_sel = 0; rec = 1'b0;
        addr[0] = 32'h0000_1000; addr[1] = 32'h0000_8000;

        // Reset held with both masters requesting.
        words_left[0] = 1; words_left[1] = 1;
        rst = 1'b0;
        drive(-1);
        @(posedge clk);
        model_step(0); model_step(1);
        @(negedge clk);
        applyStimulus();
        applyStimulus();
        checkOutput("t1_rst_gnt", 32'(ifp.gnt_o), 32'(irr.gnt_o), 32'h0);
        checkOutput("t1_rst_err", 32'(ifp.bus_err_o), 32'(irr.bus_err_o), 32'h0);
        rst = 1'b1;
        applyStimulus();
        checkOutput("t1_first_gnt", 32'(ifp.gnt_o), 32'(irr.gnt_o), 32'h2);
        runUntilIdle(40, "t1");

        // Single m0 fill, 4 words from 0x1000.
        addr[0] = 32'h0000_1000;
        words_left[0] = 4;
        runUntilIdle(40, "t2");
        check("t2_last_addr", addr[0], 32'h0000_1010);

        // Simultaneous requests.
        words_left[0] = 3; words_left[1] = 3;
        applyStimulus();
        checkOutput("t3_tie_gnt", 32'(ifp.gnt_o), 32'(irr.gnt_o), 32'h2);
        runUntilIdle(60, "t3");

        // Back-to-back bursts from both masters right after reset.
        rst = 1'b0;
        applyStimulus();
        rst = 1'b1;
        refill = 1'b1; drv_sel = 1; rec = 1'b1;
        words_left[0] = 2; words_left[1] = 2;
        repeat (30) applyStimulus();
        rec = 1'b0; refill = 1'b0;
        runUntilIdle(60, "t4");
        drv_sel = 0;
        if (gq.size() >= 5) begin
            check("t4_order0", 32'(gq[0]), 32'h2);
            check("t4_order1", 32'(gq[1]), 32'h0);
            check("t4_order2", 32'(gq[2]), 32'h1);
            check("t4_order3", 32'(gq[3]), 32'h0);
            check("t4_order4", 32'(gq[4]), 32'h2);
        end else begin
            checks++;
            errors++;
            $error("[TB] FAIL t4_order_len observed=%0d expected>=5", gq.size());
        end

        // m1 arrives in the middle of an m0 burst.
        words_left[0] = 4;
        repeat (3) applyStimulus();
        words_left[1] = 2;
        applyStimulus();
        checkOutput("t5_hold_gnt", 32'(ifp.gnt_o), 32'(irr.gnt_o), 32'h1);
        runUntilIdle(60, "t5");

        // Hung memory, then stray acks on an idle bus.
        ack_mode = 1;
        words_left[0] = 100;
        applyStimulus();
        repeat (7) applyStimulus();
        checkOutput("t6_err_cycle8", 32'(ifp.bus_err_o), 32'(irr.bus_err_o), 32'h0);
        applyStimulus();
        checkOutput("t6_err_cycle9", 32'(ifp.bus_err_o), 32'(irr.bus_err_o), 32'h1);
        checkOutput("t6_still_owned", 32'(ifp.gnt_o), 32'(irr.gnt_o), 32'h1);
        repeat (3) applyStimulus();
        words_left[0] = 0;
        applyStimulus();
        applyStimulus();
        ack_mode = 2;
        applyStimulus();
        applyStimulus();
        checkOutput("t6_err_sticky", 32'(ifp.bus_err_o), 32'(irr.bus_err_o), 32'h1);
        ack_mode = 0;
        rst = 1'b0;
        applyStimulus();
        rst = 1'b1;
        checkOutput("t6_err_cleared", 32'(ifp.bus_err_o), 32'(irr.bus_err_o), 32'h0);

        // Random traffic against the model.
        rand_cs = 1'b1; ack_mode = 3;
        repeat (400) applyStimulus();
        rand_cs = 1'b0; ack_mode = 0;
        words_left[0] = 0; words_left[1] = 0;
        runUntilIdle(20, "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
